// File: rtl/spi_touch_rx.sv
`default_nettype none
// ============================================================================
// Module  : spi_touch_rx
// Brief   : SPI-slave receiver for the touch-panel link. Oversamples the
//           SS/SCLK/MOSI pins and assembles NCH words of CW bits per frame.
//           Complete frames go to a held output with a valid/ready handshake.
//           Optional build macro SPI_PARITY_EN appends an even-parity bit.
// Rev     : 1.0  initial release
// ============================================================================
module spi_touch_rx #(
    parameter int NCH     = 3,
    parameter int CW      = 12,
    parameter int NSYNC   = 3,
    parameter int CPOL    = 0,
    parameter int CPHA    = 0,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    output logic              miso_oe,
    output logic [NCH*CW-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic [7:0]        frame_cnt
);

`ifdef SPI_PARITY_EN
    localparam int c_PAR = 1;
`else
    localparam int c_PAR = 0;
`endif
    localparam int c_DW      = NCH * CW;
    localparam int c_FW      = c_DW + c_PAR;
    localparam int c_CNT_W   = $clog2(c_FW + 2);
    localparam int c_TMR_W   = $clog2(TIMEOUT + 1);
    localparam int c_ARM_W   = $clog2(NSYNC + 2);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(c_FW);
    localparam logic [c_CNT_W-1:0] c_SAT      = c_CNT_W'(c_FW + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);
    localparam logic [c_ARM_W-1:0] c_ARM_LAST = c_ARM_W'(NSYNC + 1);
    localparam logic               c_SCLK_IDLE = (CPOL != 0);

    typedef enum logic [2:0] {
        ST_ARM    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    logic [NSYNC-1:0]   r_ss_sync;
    logic [NSYNC-1:0]   r_sclk_sync;
    logic [NSYNC-1:0]   r_mosi_sync;
    logic               r_ss_d;
    logic               r_sclk_d;
    state_t             r_state;
    logic [c_ARM_W-1:0] r_arm_cnt;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [c_TMR_W-1:0] r_timer;
    logic [c_FW-1:0]    r_shift;
    logic [7:0]         r_miso_sh;

    logic w_ss, w_sclk, w_mosi;
    logic w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;
    logic w_sample_edge, w_shift_edge, w_par_ok;
    logic [c_DW-1:0] w_frame;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ss_sync   <= '1;
            r_sclk_sync <= {NSYNC{c_SCLK_IDLE}};
            r_mosi_sync <= '0;
            r_ss_d      <= 1'b1;
            r_sclk_d    <= c_SCLK_IDLE;
        end else begin
            r_ss_sync   <= {r_ss_sync[NSYNC-2:0], SS};
            r_sclk_sync <= {r_sclk_sync[NSYNC-2:0], SCLK};
            r_mosi_sync <= {r_mosi_sync[NSYNC-2:0], MOSI};
            r_ss_d      <= r_ss_sync[NSYNC-1];
            r_sclk_d    <= r_sclk_sync[NSYNC-1];
        end
    end

    assign w_ss          = r_ss_sync[NSYNC-1];
    assign w_sclk        = r_sclk_sync[NSYNC-1];
    assign w_mosi        = r_mosi_sync[NSYNC-1];
    assign w_ss_fall     = r_ss_d & ~w_ss;
    assign w_ss_rise     = ~r_ss_d & w_ss;
    assign w_sclk_rise   = ~r_sclk_d & w_sclk;
    assign w_sclk_fall   = r_sclk_d & ~w_sclk;
    assign w_sample_edge = (CPOL == CPHA) ? w_sclk_rise : w_sclk_fall;
    assign w_shift_edge  = (CPOL == CPHA) ? w_sclk_fall : w_sclk_rise;
    assign miso_oe       = ~w_ss;

`ifdef SPI_PARITY_EN
    assign w_par_ok = ~^r_shift;
`else
    assign w_par_ok = 1'b1;
`endif

    // First word received sits at the top of the shifter and maps to ch0.
    generate
        for (genvar k = 0; k < NCH; k++) begin : g_chan
            assign w_frame[k*CW +: CW] = r_shift[c_FW-1-k*CW -: CW];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_ARM;
            r_arm_cnt <= '0;
            r_bit_cnt <= '0;
            r_timer   <= '0;
            r_shift   <= '0;
            r_miso_sh <= '0;
            MISO      <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (r_state)
                // Sync chain resets to idle, so let real pin levels flush
                // through before trusting an SS-high reading.
                ST_ARM: begin
                    if (r_arm_cnt != c_ARM_LAST) begin
                        r_arm_cnt <= r_arm_cnt + 1'b1;
                    end else if (w_ss && r_ss_d) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    MISO <= 1'b0;
                    if (w_ss_fall) begin
                        r_state   <= ST_SHIFT;
                        r_bit_cnt <= '0;
                        r_timer   <= '0;
                        if (CPHA == 0) begin
                            MISO      <= frame_cnt[7];
                            r_miso_sh <= {frame_cnt[6:0], 1'b0};
                        end else begin
                            r_miso_sh <= frame_cnt;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_ss_rise) begin
                        if (r_bit_cnt == c_FULL && w_par_ok) begin
                            r_state <= ST_COMMIT;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end else if (w_sample_edge) begin
                        r_timer <= '0;
                        r_shift <= {r_shift[c_FW-2:0], w_mosi};
                        if (r_bit_cnt != c_SAT) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (r_timer == c_TMR_LAST) begin
                        frame_err <= 1'b1;
                        r_state   <= ST_HOLD;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                    if (w_shift_edge) begin
                        MISO      <= r_miso_sh[7];
                        r_miso_sh <= {r_miso_sh[6:0], 1'b0};
                    end
                end
                ST_HOLD: begin
                    MISO <= 1'b0;
                    if (w_ss) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    data_out  <= w_frame;
                    out_valid <= 1'b1;
                    overrun   <= out_valid & ~out_ready;
                    frame_cnt <= frame_cnt + 8'd1;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_ARM;
            endcase
        end
    end

endmodule
`default_nettype wire
